// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store access stage between the pipeline MEM stage and a
//            word-wide data memory without byte enables. Accepts one RV32I
//            load/store at a time, turns B/H/W accesses into word-aligned
//            memory transactions, uses read-modify-write for sub-word
//            stores, and returns a single-cycle response pulse carrying
//            sign/zero-extended load data.
//
// Ports    : clk, rst (async, active-high), clk_en (global hold)
//            req_valid/req_ready/req_we/req_funct3/req_addr/req_wdata
//                                       - request from the MEM stage
//            resp_valid/resp_rdata/resp_err - one-cycle completion pulse
//            mem_addr/mem_rd_en/mem_wr_en/mem_wdata/mem_rdata/mem_ready
//                                       - word-wide memory port
//
// Options  : MEM_ACCESS_MISALIGN_TRAP_EN
//              defined   - misaligned H/W accesses respond with resp_err=1
//                          and never touch memory
//              undefined - misaligned H/W accesses are aligned down and
//                          complete normally
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int XLEN   = 32,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
);

    // ------------------------------------------------------------------
    // State encoding and funct3 codes
    // ------------------------------------------------------------------
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_RD     = 3'd1;
    localparam logic [2:0] c_ST_RMW_RD = 3'd2;
    localparam logic [2:0] c_ST_RMW_WR = 3'd3;
    localparam logic [2:0] c_ST_WR     = 3'd4;
    localparam logic [2:0] c_ST_RESP   = 3'd5;

    localparam logic [2:0] c_F3_B  = 3'b000;
    localparam logic [2:0] c_F3_H  = 3'b001;
    localparam logic [2:0] c_F3_BU = 3'b100;
    localparam logic [2:0] c_F3_HU = 3'b101;

    // ------------------------------------------------------------------
    // Captured request
    // ------------------------------------------------------------------
    logic [2:0]  r_state;
    logic [2:0]  r_funct3;
    logic [1:0]  r_lane;     // byte offset inside the word
    logic [15:0] r_wdata;    // only the low half is ever merged

    // ------------------------------------------------------------------
    // Request decode (evaluated on the incoming request, result captured
    // by the state register at the acceptance edge)
    // ------------------------------------------------------------------
    logic w_f3_illegal;
    logic w_misaligned;
    logic w_req_err;

    always_comb begin
        w_f3_illegal = 1'b0;
        w_misaligned = 1'b0;
        if (req_we) begin
            // Stores only have SB/SH/SW; any unsigned variant is illegal.
            w_f3_illegal = req_funct3[2] || (req_funct3 == 3'b011);
        end else begin
            w_f3_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                           (req_funct3 == 3'b111);
        end
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        case (req_funct3[1:0])
            2'b01:   w_misaligned = req_addr[0];
            2'b10:   w_misaligned = |req_addr[1:0];
            default: w_misaligned = 1'b0;
        endcase
`else
        // Low offset bits are simply ignored: halfword lanes are picked by
        // addr[1] and words by the word address, which aligns down.
        w_misaligned = 1'b0;
`endif
    end

    assign w_req_err = w_f3_illegal || w_misaligned;

    // Upper address bits lie outside the memory and are intentionally dropped.
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, req_addr[XLEN-1:MEM_AW+2]};

    // ------------------------------------------------------------------
    // Load lane extraction and store lane merge
    // ------------------------------------------------------------------
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_merge;

    always_comb begin
        w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
        w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];
        case (r_funct3)
            c_F3_B:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_BU: w_load = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_H:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_HU: w_load = {{(XLEN-16){1'b0}}, w_half};
            default: w_load = mem_rdata;
        endcase
    end

    always_comb begin
        w_merge = mem_rdata;
        if (r_funct3[1:0] == 2'b00) begin
            w_merge[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merge[{r_lane[1], 4'b0000} +: 16] = r_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. clk_en low freezes everything,
    // including the reaction to mem_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_funct3   <= 3'b000;
            r_lane     <= 2'b00;
            r_wdata    <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_addr   <= '0;
            mem_rd_en  <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_wdata  <= '0;
        end else if (clk_en) begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_funct3  <= req_funct3;
                        r_lane    <= req_addr[1:0];
                        r_wdata   <= req_wdata[15:0];
                        mem_addr  <= req_addr[MEM_AW+1:2];
                        req_ready <= 1'b0;
                        if (w_req_err) begin
                            // Rejected without touching memory.
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                            r_state    <= c_ST_RESP;
                        end else if (!req_we) begin
                            mem_rd_en <= 1'b1;
                            r_state   <= c_ST_RD;
                        end else if (req_funct3[1:0] == 2'b10) begin
                            mem_wr_en <= 1'b1;
                            mem_wdata <= req_wdata;
                            r_state   <= c_ST_WR;
                        end else begin
                            // Sub-word store: fetch the word first.
                            mem_rd_en <= 1'b1;
                            r_state   <= c_ST_RMW_RD;
                        end
                    end
                end

                c_ST_RD: begin
                    if (mem_ready) begin
                        mem_rd_en  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= w_load;
                        r_state    <= c_ST_RESP;
                    end
                end

                c_ST_RMW_RD: begin
                    if (mem_ready) begin
                        // mem_wdata doubles as the merged-word register.
                        mem_rd_en <= 1'b0;
                        mem_wr_en <= 1'b1;
                        mem_wdata <= w_merge;
                        r_state   <= c_ST_RMW_WR;
                    end
                end

                c_ST_RMW_WR,
                c_ST_WR: begin
                    if (mem_ready) begin
                        mem_wr_en  <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= '0;
                        r_state    <= c_ST_RESP;
                    end
                end

                c_ST_RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end

                default: begin
                    mem_rd_en  <= 1'b0;
                    mem_wr_en  <= 1'b0;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A behavioural word
//            memory with programmable wait states answers the DUT; expected
//            responses are queued when a request is driven and popped when
//            resp_valid appears.
// Options  : honours MEM_ACCESS_MISALIGN_TRAP_EN for misaligned expectations
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        clk_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [9:0]  mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    mem_access_unit #(.XLEN(32), .MEM_AW(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_en     (clk_en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_wr_en  (mem_wr_en),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] mem [0:1023];
    int          checks = 0;
    int          errors = 0;
    int          wait_states = 0;
    int          busy_cnt;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          wr_hold_cycles = 0;
    logic [31:0] last_wd = '0;
    logic [9:0]  last_wa = '0;
    logic        prev_rd;
    logic        prev_en = 1'b0;
    logic [9:0]  prev_addr = '0;
    logic        both_hi = 1'b0;
    logic        addr_moved = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: mem_ready after wait_states request cycles; a switch
    // from read to write (RMW) restarts the wait.
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        busy_cnt  = 0;
        prev_rd   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || !(mem_rd_en || mem_wr_en)) begin
                busy_cnt  = 0;
                mem_ready = 1'b0;
            end else begin
                if (mem_rd_en != prev_rd) busy_cnt = 0;
                mem_ready = (busy_cnt >= wait_states);
                mem_rdata = mem[mem_addr];
                if (mem_wr_en) wr_hold_cycles++;
                busy_cnt++;
            end
            prev_rd = mem_rd_en;
        end
    end

    // Memory commit and protocol observation at the active edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst && clk_en && mem_ready) begin
                if (mem_rd_en) rd_cnt++;
                if (mem_wr_en) begin
                    mem[mem_addr] = mem_wdata;
                    wr_cnt++;
                    last_wa = mem_addr;
                    last_wd = mem_wdata;
                end
            end
            if (mem_rd_en && mem_wr_en) both_hi = 1'b1;
            if ((mem_rd_en || mem_wr_en) && prev_en && (mem_addr != prev_addr)) addr_moved = 1'b1;
            prev_en   = mem_rd_en || mem_wr_en;
            prev_addr = mem_addr;
        end
    end

    // One request; gate_at>0 drops clk_en for 4 cycles at that cycle count.
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_rd, input int exp_wr,
                          input logic [31:0] exp_wd, input int gate_at);
        exp_t e;
        exp_t got;
        int   lat;
        int   rd0;
        int   wr0;
        bit   done;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        sb_q.push_back(e);
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        @(negedge clk);
        chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
        chk({tag, "_idle_resp"}, {31'b0, resp_valid}, 32'd0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        lat  = 0;
        done = 1'b0;
        while (!done && lat < 40) begin
            @(negedge clk);
            req_valid = 1'b0;
            lat++;
            if (lat == gate_at) begin
                chk({tag, "_gate_wr_en"}, {31'b0, mem_wr_en}, 32'd1);
                clk_en = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    lat++;
                    chk({tag, "_hold_wr_en"}, {31'b0, mem_wr_en}, 32'd1);
                    chk({tag, "_hold_wdata"}, mem_wdata, exp_wd);
                    chk({tag, "_hold_noresp"}, {31'b0, resp_valid}, 32'd0);
                end
                clk_en = 1'b1;
            end
            if (resp_valid) begin
                done = 1'b1;
                got  = sb_q.pop_front();
                chk({tag, "_rdata"}, resp_rdata, got.rdata);
                chk({tag, "_err"}, {31'b0, resp_err}, {31'b0, got.err});
                chk({tag, "_latency"}, lat, got.lat);
                chk({tag, "_ready_low"}, {31'b0, req_ready}, 32'd0);
                chk({tag, "_rd_count"}, rd_cnt - rd0, exp_rd);
                chk({tag, "_wr_count"}, wr_cnt - wr0, exp_wr);
                if (exp_wr > 0) chk({tag, "_wr_data"}, last_wd, exp_wd);
            end
        end
        if (!done) begin
            got = sb_q.pop_front();
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end
    endtask

    initial begin
        int seen;
        rst = 1'b1;
        clk_en = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'b000;
        req_addr = '0;
        req_wdata = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        mem[5] = 32'h80FF_7F01;
        mem[3] = 32'h1122_3344;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("rst_wr_en", {31'b0, mem_wr_en}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_addr", {22'b0, mem_addr}, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        // Loads: byte lane 3 = 0x80, lane 2 = 0xFF, half 0 = 0x7F01, half 1 = 0x80FF
        do_req("lb_17",  1'b0, 3'b000, 32'h17, 32'h0, 32'hFFFF_FF80, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lbu_17", 1'b0, 3'b100, 32'h17, 32'h0, 32'h0000_0080, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lb_16",  1'b0, 3'b000, 32'h16, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lh_14",  1'b0, 3'b001, 32'h14, 32'h0, 32'h0000_7F01, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lh_16",  1'b0, 3'b001, 32'h16, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lhu_16", 1'b0, 3'b101, 32'h16, 32'h0, 32'h0000_80FF, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lw_14",  1'b0, 3'b010, 32'h14, 32'h0, 32'h80FF_7F01, 1'b0, 2, 1, 0, 32'h0, 0);

        // Sub-word stores via read-modify-write
        do_req("sb_0d", 1'b1, 3'b000, 32'h0D, 32'h0000_00AB, 32'h0, 1'b0, 3, 1, 1, 32'h1122_AB44, 0);
        chk("sb_0d_word", last_wa, 32'd3);
        do_req("sh_0e", 1'b1, 3'b001, 32'h0E, 32'h5566_CAFE, 32'h0, 1'b0, 3, 1, 1, 32'hCAFE_AB44, 0);

        // Word store with 3 wait states
        wait_states = 3;
        wr_hold_cycles = 0;
        do_req("sw_20", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0, 1'b0, 5, 0, 1, 32'hDEAD_BEEF, 0);
        chk("sw_20_hold", wr_hold_cycles, 32'd4);
        chk("sw_20_word", last_wa, 32'd8);
        wait_states = 0;

        // Misaligned accesses
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        do_req("lw_22_mis", 1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        do_req("lh_15_mis", 1'b0, 3'b001, 32'h15, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
`else
        do_req("lw_22_mis", 1'b0, 3'b010, 32'h22, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1, 0, 32'h0, 0);
        do_req("lh_15_mis", 1'b0, 3'b001, 32'h15, 32'h0, 32'h0000_7F01, 1'b0, 2, 1, 0, 32'h0, 0);
`endif

        // Illegal funct3, both directions
        do_req("ld_f3_011", 1'b0, 3'b011, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        do_req("ld_f3_110", 1'b0, 3'b110, 32'h14, 32'h0, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        do_req("st_f3_100", 1'b1, 3'b100, 32'h0C, 32'h1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);
        do_req("st_f3_011", 1'b1, 3'b011, 32'h0C, 32'h1, 32'h0, 1'b1, 1, 0, 0, 32'h0, 0);

        // clk_en dropped for 4 cycles while in RMW_WR with mem_ready high
        do_req("sb_gate", 1'b1, 3'b000, 32'h0C, 32'h0000_0077, 32'h0, 1'b0, 7, 1, 1, 32'hCAFE_AB77, 2);
        chk("sb_gate_mem", mem[3], 32'hCAFE_AB77);

        // Reset in the middle of a waited read aborts it silently
        wait_states = 6;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h14;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rd_en_before", {31'b0, mem_rd_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_rd_en", {31'b0, mem_rd_en}, 32'd0);
        chk("abort_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_states = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("abort_no_resp", seen, 32'd0);
        do_req("lw_recover", 1'b0, 3'b010, 32'h14, 32'h0, 32'h80FF_7F01, 1'b0, 2, 1, 0, 32'h0, 0);

        chk("rd_wr_exclusive", {31'b0, both_hi}, 32'd0);
        chk("addr_stable", {31'b0, addr_moved}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
